// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, keyboard command bytes,
// default timing and the host frame payload.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] BREAK        = 8'hF0;

  localparam int unsigned DEF_INHIBIT_CYCLES = 5000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 750000;
  localparam int unsigned DEF_SYNC_LEN       = 8;

  // Bits shifted out after the start bit: data LSB first, then parity.
  typedef struct packed {
    logic       parity;
    logic [7:0] data;
  } ps2_frame_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte-request and status handshake between a command source and ps2_host_tx.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  modport master (output tx_data, tx_valid, input tx_ready, busy, tx_done, tx_err);
  modport slave  (input tx_data, tx_valid, output tx_ready, busy, tx_done, tx_err);
endinterface

// File: rtl/ps2_clk_sync.sv
// ps2clk sample history with a glitch-filtered falling-edge pulse; shared with
// the keyboard receiver.
module ps2_clk_sync
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_LEN = DEF_SYNC_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2clk_in,
  output logic fall_c,
  output logic level_c
);

  localparam int unsigned HALF = SYNC_LEN / 2;

  logic [SYNC_LEN-1:0] hist_q;

  // Newest sample enters at bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= '0;
    else       hist_q <= {hist_q[SYNC_LEN-2:0], ps2clk_in};
  end

  assign fall_c  = (&hist_q[SYNC_LEN-1:HALF]) & ~(|hist_q[HALF-1:0]);
  assign level_c = hist_q[0];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, frame shift, ACK check.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned SYNC_LEN       = DEF_SYNC_LEN
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ps2clk_in,
  input  logic          ps2data_in,
  output logic          ps2clk_oe,
  output logic          ps2data_oe,
  ps2_host_tx_if.slave  bus
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > SYNC_LEN) ? INHIBIT_CYCLES : SYNC_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  if ((SYNC_LEN % 2) != 0 || SYNC_LEN < 2 || INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("ps2_host_tx: illegal parameter combination");
  end

  ps2_tx_state_e    state_q, state_d;
  ps2_frame_t       frame_q, frame_d;
  logic [3:0]       n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nak_q, nak_d;
  logic             data_meta_q, data_s_q;
  logic             clk_oe_d, data_oe_d, ready_d, busy_d, done_d, err_d;
  logic             fall_c, level_c, accept_c, line_idle_c, timeout_c;
  logic [8:0]       frame_bits_c;

  ps2_clk_sync #(.SYNC_LEN(SYNC_LEN)) u_clk_sync (
    .clk       (clk),
    .reset     (reset),
    .ps2clk_in (ps2clk_in),
    .fall_c    (fall_c),
    .level_c   (level_c)
  );

  assign accept_c     = bus.tx_valid & bus.tx_ready;
  assign line_idle_c  = level_c & data_s_q;
  assign frame_bits_c = frame_q;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            armed_c;

  // Watchdog runs from the accept edge until the ACK bit is sampled.
  assign armed_c = (state_q == INHIBIT) || (state_q == RTS) ||
                   (state_q == SEND)    || (state_q == ACK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         wd_q <= '0;
    else if (accept_c) wd_q <= WD_W'(1);
    else if (armed_c)  wd_q <= wd_q + WD_W'(1);
  end

  assign timeout_c = armed_c && (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) &&
                     !((state_q == ACK) && fall_c);
`else
  assign timeout_c = 1'b0;
`endif

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      frame_q      <= '0;
      n_q          <= '0;
      cnt_q        <= '0;
      nak_q        <= 1'b0;
      data_meta_q  <= 1'b0;
      data_s_q     <= 1'b0;
      ps2clk_oe    <= 1'b0;
      ps2data_oe   <= 1'b0;
      bus.tx_ready <= 1'b1;
      bus.busy     <= 1'b0;
      bus.tx_done  <= 1'b0;
      bus.tx_err   <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      nak_q        <= nak_d;
      data_meta_q  <= ps2data_in;
      data_s_q     <= data_meta_q;
      ps2clk_oe    <= clk_oe_d;
      ps2data_oe   <= data_oe_d;
      bus.tx_ready <= ready_d;
      bus.busy     <= busy_d;
      bus.tx_done  <= done_d;
      bus.tx_err   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (accept_c) state_d = INHIBIT;
      INHIBIT:   if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) state_d = RTS;
      RTS:       state_d = SEND;
      SEND:      if (fall_c && (n_q == 4'd9)) state_d = ACK;
      ACK:       if (fall_c) state_d = WAIT_IDLE;
      WAIT_IDLE: if (line_idle_c && (cnt_q == CNT_W'(SYNC_LEN - 1))) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (timeout_c) state_d = IDLE;
  end

  // Datapath and next values of the registered outputs.
  always_comb begin
    frame_d   = frame_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    nak_d     = nak_q;
    clk_oe_d  = ps2clk_oe;
    data_oe_d = ps2data_oe;
    ready_d   = bus.tx_ready;
    busy_d    = bus.busy;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          frame_d.data   = bus.tx_data;
          frame_d.parity = odd_parity(bus.tx_data);
          n_d            = '0;
          cnt_d          = '0;
          clk_oe_d       = 1'b1;
          data_oe_d      = 1'b0;
          ready_d        = 1'b0;
          busy_d         = 1'b1;
        end
      end
      INHIBIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) data_oe_d = 1'b1;
      end
      RTS: clk_oe_d = 1'b0;
      SEND: begin
        // Indices 0..8 drive data then parity; index 9 releases for the stop bit.
        if (fall_c) begin
          data_oe_d = (n_q < 4'd9) ? ~frame_bits_c[n_q] : 1'b0;
          n_d       = n_q + 4'd1;
        end
      end
      ACK: begin
        if (fall_c) begin
          nak_d = data_s_q;
          cnt_d = '0;
        end
      end
      WAIT_IDLE: begin
        if (!line_idle_c) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(SYNC_LEN - 1)) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          err_d   = nak_q;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    if (timeout_c) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b1;
      err_d     = 1'b1;
      ready_d   = 1'b1;
      busy_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model on the open-drain lines, frame
// reference computed from the byte, directed and random transfers.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH    = 16;
  localparam int unsigned TMO    = 2000;
  localparam int unsigned SL     = 8;
  localparam int          HALF_P = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2clk_oe, ps2data_oe;
  logic ps2clk_line, ps2data_line;

  int n_checks = 0;
  int n_fail = 0;
  int n_accept = 0;
  int n_done = 0;
  int exp_accept = 0;
  int exp_done = 0;
  bit scramble = 1'b0;

  always #5 clk = ~clk;

  assign ps2clk_line  = ~(ps2clk_oe | dev_clk_low);
  assign ps2data_line = ~(ps2data_oe | dev_data_low);

  ps2_host_tx_if bus();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_LEN       (SL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2clk_in  (ps2clk_line),
    .ps2data_in (ps2data_line),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe),
    .bus        (bus)
  );

  always @(posedge clk) if (!reset && bus.tx_valid && bus.tx_ready) n_accept++;
  always @(negedge clk) if (bus.tx_done) n_done++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line levels seen by the device: {stop, parity, data LSB first, start}.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (scramble) bus.tx_data = 8'($urandom);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 1000 && !bus.tx_ready; i++) @(negedge clk);
    check_eq("ready_before_send", 32'(bus.tx_ready), 32'd1);
  endtask

  // One host transfer with the device clocking; abort_at >= 0 resets after that many falls.
  task automatic do_send(input logic [7:0] d, input bit ack, input bit hold, input int abort_at);
    logic [10:0] got;
    logic [10:0] exp;
    int inh, rts;
    bit started, seen;
    got = '0;
    inh = 0;
    rts = 0;
    started = 1'b0;
    seen = 1'b0;
    exp = ref_frame(d);
    wait_ready();
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    exp_accept++;
    scramble = hold;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (i == 0) begin
        check_eq("ready_low_after_accept", 32'(bus.tx_ready), 32'd0);
        check_eq("busy_after_accept", 32'(bus.busy), 32'd1);
        if (!hold) bus.tx_valid = 1'b0;
      end
      if (ps2clk_oe && !ps2data_oe) inh++;
      else if (ps2clk_oe && ps2data_oe) rts++;
      else if (ps2data_oe) begin
        started = 1'b1;
        break;
      end
    end
    check_eq("send_started", 32'(started), 32'd1);
    check_eq("inhibit_cycles", 32'(inh), 32'(INH));
    check_eq("rts_cycles", 32'(rts), 32'd1);
    got[0] = ps2data_line;
    tick(HALF_P);
    for (int i = 0; i < 10; i++) begin
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        check_eq("reset_clk_oe", 32'(ps2clk_oe), 32'd0);
        check_eq("reset_data_oe", 32'(ps2data_oe), 32'd0);
        check_eq("reset_ready", 32'(bus.tx_ready), 32'd1);
        check_eq("reset_busy", 32'(bus.busy), 32'd0);
        scramble = 1'b0;
        bus.tx_valid = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);
        return;
      end
      dev_clk_low = 1'b1;
      tick(HALF_P);
      dev_clk_low = 1'b0;
      got[i+1] = ps2data_line;
      tick(HALF_P);
    end
    check_eq("frame", 32'(got), 32'(exp));
    check_eq("parity_bit", 32'(got[9]), 32'(exp[9]));
    dev_data_low = ack;
    dev_clk_low  = 1'b1;
    tick(HALF_P);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    exp_done++;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (bus.tx_done) begin
        seen = 1'b1;
        break;
      end
    end
    bus.tx_valid = 1'b0;
    scramble = 1'b0;
    check_eq("done_seen", 32'(seen), 32'd1);
    check_eq("err_flag", 32'(bus.tx_err), 32'(!ack));
    check_eq("done_clk_oe", 32'(ps2clk_oe), 32'd0);
    check_eq("done_data_oe", 32'(ps2data_oe), 32'd0);
    tick(1);
    check_eq("done_pulse_width", 32'(bus.tx_done), 32'd0);
    check_eq("idle_busy", 32'(bus.busy), 32'd0);
    check_eq("idle_ready", 32'(bus.tx_ready), 32'd1);
  endtask

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_clk_oe", 32'(ps2clk_oe), 32'd0);
    check_eq("rst_data_oe", 32'(ps2data_oe), 32'd0);
    check_eq("rst_ready", 32'(bus.tx_ready), 32'd1);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.tx_done), 32'd0);
    check_eq("rst_err", 32'(bus.tx_err), 32'd0);
    reset = 1'b0;
    tick(SL + 2);

    do_send(CMD_SET_LEDS, 1'b1, 1'b0, -1);
    do_send(8'h00, 1'b1, 1'b0, -1);
    do_send(8'h01, 1'b1, 1'b0, -1);
    do_send(CMD_ECHO, 1'b0, 1'b0, -1);
    do_send(8'hA5, 1'b1, 1'b0, 4);
    do_send(CMD_RESET, 1'b1, 1'b0, -1);
    do_send(8'h3C, 1'b1, 1'b1, -1);
    for (int r = 0; r < 6; r++) begin
      do_send(8'($urandom), ($urandom_range(0, 3) != 0), 1'b0, -1);
    end

`ifdef PS2_TX_TIMEOUT_EN
    begin
      int k;
      k = 0;
      wait_ready();
      bus.tx_data  = 8'h55;
      bus.tx_valid = 1'b1;
      exp_accept++;
      exp_done++;
      for (int i = 1; i <= 3000; i++) begin
        @(negedge clk);
        if (i == 1) bus.tx_valid = 1'b0;
        if (bus.tx_err) begin
          k = i;
          break;
        end
      end
      check_eq("timeout_cycle", 32'(k), 32'(TMO));
      check_eq("timeout_done", 32'(bus.tx_done), 32'd1);
      check_eq("timeout_data_oe", 32'(ps2data_oe), 32'd0);
      check_eq("timeout_clk_oe", 32'(ps2clk_oe), 32'd0);
      @(negedge clk);
      check_eq("timeout_ready", 32'(bus.tx_ready), 32'd1);
    end
`endif

    tick(5);
    check_eq("accept_count", 32'(n_accept), 32'(exp_accept));
    check_eq("done_count", 32'(n_done), 32'(exp_done));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, e.g. 0xED set-LEDs with its argument byte, or 0xFF reset. It drives the open-drain ps2clk/ps2data lines through active-high pull-low enables and runs the inhibit/request-to-send sequence. It shifts out data, parity and stop bits on device-generated clock edges, then checks the device ACK. It sits beside the keyboard receiver, which ignores the bus while busy=1.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2clk is held low before request-to-send (100 us at 50 MHz)
TIMEOUT_CYCLES, 750000, watchdog limit in clk cycles from leaving IDLE until ACK sampled (15 ms at 50 MHz)
SYNC_LEN, 8, ps2clk sample history length used for falling-edge detection (must be even)

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high
ps2clk_in  input  1  raw ps2clk line level
ps2data_in  input  1  raw ps2data line level
ps2clk_oe  output  1  1 = pull ps2clk low, 0 = release
ps2data_oe  output  1  1 = pull ps2data low, 0 = release
tx_data  input  8  byte to send, sampled on accept
tx_valid  input  1  request to send tx_data
tx_ready  output  1  1 only in IDLE; accept when tx_valid & tx_ready
busy  output  1  1 in every state except IDLE
tx_done  output  1  one-cycle pulse at end of transfer (success or error)
tx_err  output  1  one-cycle pulse coincident with tx_done when ACK is missing or timeout occurs

Behaviour:
- Reset, at any time including mid-transfer: ps2clk_oe=0, ps2data_oe=0, tx_ready=1, busy=0, tx_done=0, tx_err=0; state=IDLE; counters and sample history cleared.
- Falling edge (fall): the ps2clk_in history shifts every clk. fall=1 when the oldest SYNC_LEN/2 samples are all 1 and the newest SYNC_LEN/2 are all 0. This is a one-cycle pulse, with latency SYNC_LEN/2 cycles after the real edge.
- IDLE: lines released. On accept, latch shift={parity, tx_data}, where parity = ~^tx_data (odd parity). Set bit counter n=0 and go to INHIBIT.
- INHIBIT: ps2clk_oe=1 for exactly INHIBIT_CYCLES clk cycles, then go to RTS.
- RTS: one cycle with ps2clk_oe=1 and ps2data_oe=1 (start bit), then go to SEND with ps2clk_oe=0 and ps2data_oe still 1.
- SEND: on each fall:
  - n=0..8: ps2data_oe <= ~shift[n], giving data bits LSB first, then parity.
  - n=9: ps2data_oe <= 0 (stop bit, line released).
  - n increments each fall.
  - At n=10, go to ACK.
- ACK: on the next fall, sample ps2data_in. A 0 is a valid ACK; a 1 means a NAK error. Go to WAIT_IDLE.
- WAIT_IDLE: wait until ps2clk_in=1 and ps2data_in=1 hold together for SYNC_LEN consecutive cycles. Then pulse tx_done, with tx_err=1 if NAK. Return to IDLE.
- tx_valid while busy is ignored: no queueing, and tx_data changes after accept have no effect.
- fall pulses seen in IDLE, INHIBIT or RTS are ignored.
- Outputs are registered; tx_ready goes low the cycle after accept.

Optional Feature:
PS2_TX_TIMEOUT_EN
- Defined: a watchdog counts clk cycles from leaving IDLE. If ACK has not been sampled when the count reaches TIMEOUT_CYCLES, then in the same cycle: release both lines, pulse tx_done and tx_err, and go to IDLE.
- Undefined: no watchdog, and a silent device leaves the block busy until reset.

Decomposition:
- Package ps2_pkg holds:
  - state encoding (IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE);
  - command constants CMD_SET_LEDS=8'hED, CMD_ECHO=8'hEE, CMD_RESET=8'hFF, RSP_ACK=8'hFA, BREAK=8'hF0;
  - default timing constants.
- Sub-module ps2_clk_sync (ps2clk sample history plus fall detect), shared with the keyboard receiver.

Test Plan:
- INHIBIT_CYCLES=16, tx_data=8'hED, device model clocks at 1/40 clk -> ps2clk_oe high for exactly 16 cycles. Device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Device ACKs -> tx_done=1, tx_err=0, busy=0.
- tx_data=8'h00 -> device samples parity bit 1; tx_data=8'h01 -> parity bit 0.
- Device omits ACK (data stays high at 11th fall) -> tx_done and tx_err pulse together, both lines released.
- With PS2_TX_TIMEOUT_EN, TIMEOUT_CYCLES=2000, device never clocks -> tx_err at cycle 2000 after accept, ps2data_oe=0, tx_ready=1 next cycle.
- Assert reset during SEND after 4 falls -> both oe=0 immediately, tx_ready=1. A new send of 8'hFF afterwards completes normally.
- tx_valid held high while busy with changing tx_data -> only the first byte is sent, and exactly one tx_done per accept.
